// File: rtl/msrv32_pkg.sv
// -----------------------------------------------------------------------------
// msrv32_pkg
// Shared constants and types for the RV32I integer register file.
//   XLEN      : data width of one register
//   REG_CNT   : number of architectural registers (x0..x31)
//   REG_AW    : register index width
//   rf_state_e: register-file FSM states (CLEAR walk, READY)
// -----------------------------------------------------------------------------
package msrv32_pkg;

    localparam int XLEN    = 32;
    localparam int REG_CNT = 32;
    localparam int REG_AW  = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam logic [REG_AW-1:0] ZERO_REG_IDX  = '0;
    localparam logic [REG_AW-1:0] FIRST_CLR_IDX = REG_AW'(1);
    localparam logic [REG_AW-1:0] LAST_REG_IDX  = REG_AW'(REG_CNT - 1);

endpackage

// File: rtl/msrv32_integer_file_unit_if.sv
// -----------------------------------------------------------------------------
// msrv32_integer_file_unit_if
// Bundle between the write-back / decode side (master) and the register file
// (slave).
//   wr_en_in      : write enable from write-back control
//   rd_addr_in    : destination register index
//   rd_in         : write-back mux result
//   rs_1_addr_in  : read port 1 index
//   rs_2_addr_in  : read port 2 index
//   rs_1_out      : read port 1 data (combinational)
//   rs_2_out      : read port 2 data (combinational)
//   rf_ready_out  : high once the post-reset clear walk has finished
// -----------------------------------------------------------------------------
interface msrv32_integer_file_unit_if;
    import msrv32_pkg::*;

    logic              wr_en_in;
    logic [REG_AW-1:0] rd_addr_in;
    logic [XLEN-1:0]   rd_in;
    logic [REG_AW-1:0] rs_1_addr_in;
    logic [REG_AW-1:0] rs_2_addr_in;
    logic [XLEN-1:0]   rs_1_out;
    logic [XLEN-1:0]   rs_2_out;
    logic              rf_ready_out;

    modport master (
        output wr_en_in, rd_addr_in, rd_in, rs_1_addr_in, rs_2_addr_in,
        input  rs_1_out, rs_2_out, rf_ready_out
    );

    modport slave (
        input  wr_en_in, rd_addr_in, rd_in, rs_1_addr_in, rs_2_addr_in,
        output rs_1_out, rs_2_out, rf_ready_out
    );

endinterface

// File: rtl/msrv32_rf_read_port.sv
// -----------------------------------------------------------------------------
// msrv32_rf_read_port
// One combinational read port of the integer register file.
//   i_rs_addr  : register index to read
//   i_rf_view  : view of the storage array
//   i_wr_en    : write enable           (only with MSRV32_RF_BYPASS_EN)
//   i_wr_addr  : write index            (only with MSRV32_RF_BYPASS_EN)
//   i_wr_data  : write data             (only with MSRV32_RF_BYPASS_EN)
//   i_rf_ready : register file is in READY (and not in reset)
//   o_rs_data  : read data
// Returns 0 for x0 and whenever the file is not ready. With the macro
// MSRV32_RF_BYPASS_EN defined, a same-cycle write to the addressed register is
// forwarded (write-first); otherwise the old stored value is returned.
// -----------------------------------------------------------------------------
module msrv32_rf_read_port
    import msrv32_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [XLEN-1:0]   i_rf_view [REG_CNT],
`ifdef MSRV32_RF_BYPASS_EN
    input  logic              i_wr_en,
    input  logic [REG_AW-1:0] i_wr_addr,
    input  logic [XLEN-1:0]   i_wr_data,
`endif
    input  logic              i_rf_ready,
    output logic [XLEN-1:0]   o_rs_data
);

    always_comb begin
        // NOTE: assigning a default before any condition keeps this block
        // purely combinational; a missing path would otherwise infer a latch.
        o_rs_data = '0;
        if (i_rf_ready && (i_rs_addr != ZERO_REG_IDX)) begin
            o_rs_data = i_rf_view[i_rs_addr];
`ifdef MSRV32_RF_BYPASS_EN
            // i_rs_addr is already known non-zero, so equality implies the
            // write is not to x0.
            if (i_wr_en && (i_wr_addr == i_rs_addr)) begin
                o_rs_data = i_wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/msrv32_integer_file_unit.sv
// -----------------------------------------------------------------------------
// msrv32_integer_file_unit
// RV32I integer register file fed by the write-back mux.
//   ms_riscv32_mp_clk_in : core clock, rising edge
//   ms_riscv32_mp_rst_in : synchronous active-low reset
//   rf_bus (slave)       : write port, two read ports, ready flag
// After reset a CLEAR walk zeroes x1..x31, one entry per cycle; external
// writes are dropped and reads return 0 until READY. x0 is hard-wired to 0.
// Optional feature macro: MSRV32_RF_BYPASS_EN (write-first read forwarding).
// -----------------------------------------------------------------------------
module msrv32_integer_file_unit
    import msrv32_pkg::*;
(
    input  logic                             ms_riscv32_mp_clk_in,
    input  logic                             ms_riscv32_mp_rst_in,
    msrv32_integer_file_unit_if.slave        rf_bus
);

    rf_state_e         r_state;
    rf_state_e         w_next_state;
    logic [REG_AW-1:0] r_clr_idx;
    logic [REG_AW-1:0] w_next_clr_idx;

    logic [XLEN-1:0]   r_rf [REG_CNT];
    logic              w_rf_we;
    logic [REG_AW-1:0] w_rf_waddr;
    logic [XLEN-1:0]   w_rf_wdata;
    logic              w_rf_ready;

    // FSM state register
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!ms_riscv32_mp_rst_in) begin
            r_state   <= CLEAR;
            r_clr_idx <= FIRST_CLR_IDX;
        end else begin
            r_state   <= w_next_state;
            r_clr_idx <= w_next_clr_idx;
        end
    end

    // Next state and the single storage write port: the clear walk owns the
    // port in CLEAR, the write-back stage owns it in READY.
    always_comb begin
        w_next_state   = r_state;
        w_next_clr_idx = r_clr_idx;
        w_rf_we        = 1'b0;
        w_rf_waddr     = r_clr_idx;
        w_rf_wdata     = '0;
        case (r_state)
            CLEAR: begin
                w_rf_we = 1'b1;
                // Stop at the last index rather than letting the 5-bit
                // counter wrap back onto x0.
                if (r_clr_idx == LAST_REG_IDX) begin
                    w_next_state = READY;
                end else begin
                    w_next_clr_idx = r_clr_idx + REG_AW'(1);
                end
            end
            READY: begin
                if (rf_bus.wr_en_in && (rf_bus.rd_addr_in != ZERO_REG_IDX)) begin
                    w_rf_we    = 1'b1;
                    w_rf_waddr = rf_bus.rd_addr_in;
                    w_rf_wdata = rf_bus.rd_in;
                end
            end
            default: begin
                w_next_state = CLEAR;
            end
        endcase
    end

    // Storage. Entry 0 is never written; the read ports force x0 to zero.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        // NOTE: the array has no reset branch so it maps onto plain RAM/flops
        // without reset wiring; the CLEAR walk zeroes it instead.
        if (ms_riscv32_mp_rst_in && w_rf_we) begin
            r_rf[w_rf_waddr] <= w_rf_wdata;
        end
    end

    // Gating with reset keeps the outputs at 0 throughout reset, including
    // the cycle before the first reset edge.
    assign w_rf_ready          = ms_riscv32_mp_rst_in && (r_state == READY);
    assign rf_bus.rf_ready_out = w_rf_ready;

    msrv32_rf_read_port u_rd_port_1 (
        .i_rs_addr  (rf_bus.rs_1_addr_in),
        .i_rf_view  (r_rf),
`ifdef MSRV32_RF_BYPASS_EN
        .i_wr_en    (rf_bus.wr_en_in),
        .i_wr_addr  (rf_bus.rd_addr_in),
        .i_wr_data  (rf_bus.rd_in),
`endif
        .i_rf_ready (w_rf_ready),
        .o_rs_data  (rf_bus.rs_1_out)
    );

    msrv32_rf_read_port u_rd_port_2 (
        .i_rs_addr  (rf_bus.rs_2_addr_in),
        .i_rf_view  (r_rf),
`ifdef MSRV32_RF_BYPASS_EN
        .i_wr_en    (rf_bus.wr_en_in),
        .i_wr_addr  (rf_bus.rd_addr_in),
        .i_wr_data  (rf_bus.rd_in),
`endif
        .i_rf_ready (w_rf_ready),
        .o_rs_data  (rf_bus.rs_2_out)
    );

endmodule

// File: tb/tb_msrv32_integer_file_unit.sv
// -----------------------------------------------------------------------------
// tb_msrv32_integer_file_unit
// Directed self-checking bench for msrv32_integer_file_unit. Honors
// MSRV32_RF_BYPASS_EN for the same-cycle read expectation.
// -----------------------------------------------------------------------------
module tb_msrv32_integer_file_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    msrv32_integer_file_unit_if rf_if ();

    msrv32_integer_file_unit dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .rf_bus               (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and step off it so inputs change away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
        rf_if.wr_en_in   = en;
        rf_if.rd_addr_in = addr;
        rf_if.rd_in      = data;
    endtask

    // Release reset and run the 31-cycle walk, checking ready timing.
    task automatic walk(input string tag);
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            #1;
            check({tag, "_ready"}, 32'(rf_if.rf_ready_out), (k == 31) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);
        rf_if.rs_1_addr_in = 5'd5;
        rf_if.rs_2_addr_in = 5'd5;

        // Reset held low for three edges.
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            check("rst_ready", 32'(rf_if.rf_ready_out), 32'd0);
            check("rst_rs1", rf_if.rs_1_out, 32'h0);
            check("rst_rs2", rf_if.rs_2_out, 32'h0);
        end

        // Clear walk; a write to x7 is offered on the 5th edge and dropped.
        rst_n = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            if (k == 5) set_wr(1'b1, 5'd7, 32'hDEADBEEF);
            tick();
            if (k == 5) set_wr(1'b0, 5'd0, 32'h0);
            #1;
            check("walk_ready", 32'(rf_if.rf_ready_out), (k == 31) ? 32'd1 : 32'd0);
            if (k < 31) check("walk_rs1_x5", rf_if.rs_1_out, 32'h0);
        end
        rf_if.rs_1_addr_in = 5'd7;
        #1;
        check("clear_drop_x7", rf_if.rs_1_out, 32'h0);
        check("ready_rs2_x5", rf_if.rs_2_out, 32'h0);

        // READY writes with next-cycle reads.
        set_wr(1'b1, 5'd1, 32'hAABBCCDD);
        tick();
        set_wr(1'b1, 5'd2, 32'h00112233);
        rf_if.rs_1_addr_in = 5'd1;
        #1;
        check("rd_x1", rf_if.rs_1_out, 32'hAABBCCDD);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        rf_if.rs_2_addr_in = 5'd2;
        #1;
        check("rd_x2", rf_if.rs_2_out, 32'h00112233);
        check("rd_x1_hold", rf_if.rs_1_out, 32'hAABBCCDD);

        // x0 protection, including a same-cycle read of x0 during the write.
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
        rf_if.rs_1_addr_in = 5'd0;
        rf_if.rs_2_addr_in = 5'd0;
        #1;
        check("x0_same_rs1", rf_if.rs_1_out, 32'h0);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        #1;
        check("x0_rs1", rf_if.rs_1_out, 32'h0);
        check("x0_rs2", rf_if.rs_2_out, 32'h0);

        // Same-cycle read of the register being written.
        set_wr(1'b1, 5'd3, 32'h99999999);
        tick();
        set_wr(1'b1, 5'd3, 32'h12345678);
        rf_if.rs_1_addr_in = 5'd3;
        rf_if.rs_2_addr_in = 5'd1;
        #1;
`ifdef MSRV32_RF_BYPASS_EN
        check("same_cyc_rs1", rf_if.rs_1_out, 32'h12345678);
`else
        check("same_cyc_rs1", rf_if.rs_1_out, 32'h99999999);
`endif
        check("same_cyc_rs2_other", rf_if.rs_2_out, 32'hAABBCCDD);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        rf_if.rs_2_addr_in = 5'd3;
        #1;
        check("after_wr_rs1_x3", rf_if.rs_1_out, 32'h12345678);
        check("after_wr_rs2_x3", rf_if.rs_2_out, 32'h12345678);

        // Reset at cycle 10 of a walk.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            #1;
            check("mid_walk_ready", 32'(rf_if.rf_ready_out), 32'd0);
        end
        rst_n = 1'b0;
        tick();
        #1;
        check("mid_walk_rst_ready", 32'(rf_if.rf_ready_out), 32'd0);
        walk("rewalk");

        // Write x4, then reset in READY and confirm it is cleared.
        set_wr(1'b1, 5'd4, 32'h0000ABCD);
        tick();
        set_wr(1'b0, 5'd0, 32'h0);
        rf_if.rs_1_addr_in = 5'd4;
        #1;
        check("rd_x4", rf_if.rs_1_out, 32'h0000ABCD);
        rst_n = 1'b0;
        #1;
        check("rst_comb_ready", 32'(rf_if.rf_ready_out), 32'd0);
        check("rst_comb_rs1", rf_if.rs_1_out, 32'h0);
        tick();
        #1;
        check("rdy_rst_ready", 32'(rf_if.rf_ready_out), 32'd0);
        walk("ready_rewalk");
        #1;
        check("x4_cleared", rf_if.rs_1_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
